// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch / load-store memory port arbiter:
// grant state encoding, RV32 width codes and default geometry.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 12;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know signed-agnostic B/H/W; loads additionally accept the
  // zero-extending BU/HU variants. Everything else is an illegal width code.
  function automatic logic func3_legal(input logic we, input logic [2:0] func3);
    logic ok;
    ok = 1'b0;
    case (func3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational legality check for a load/store: flags illegal width codes
// and accesses that are not naturally aligned for their width.
module mem_align_check
  import mem_arb_pkg::*;
(
  input  logic       we,
  input  logic [2:0] func3,
  input  logic [1:0] addr_lsb,
  output logic       err
);

  logic illegal;
  logic misaligned;

  // Words need both low address bits clear, halfwords only bit 0; bytes never misalign.
  always_comb begin
    illegal    = !func3_legal(we, func3);
    misaligned = 1'b0;
    case (func3)
      F3_W:        misaligned = (addr_lsb != 2'b00);
      F3_H, F3_HU: misaligned = addr_lsb[0];
      default:     misaligned = 1'b0;
    endcase
    err = illegal | misaligned;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// the load/store unit. One access per cycle, registered grant, data has
// priority unless fetch has been starved for STARVE_LIMIT data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_func3,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned       CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_cnt_next;

  // Transaction captured at arbitration so the access cycle is driven purely from registers.
  logic [ADDR_W-1:0] gnt_addr;
  logic [2:0]        gnt_func3;
  logic [DATA_W-1:0] gnt_wdata;
  logic              gnt_we;
  logic              gnt_err;

  logic              i_elig;
  logic              d_elig;
  logic              fetch_first;
  logic              d_chk_err;

  mem_align_check u_align_check (
    .we       (d_we),
    .func3    (d_func3),
    .addr_lsb (d_addr[1:0]),
    .err      (d_chk_err)
  );

  // Arbitration: a port is masked in its grant and ack cycles because a still-high
  // request there is the transaction already being served.
  always_comb begin
    state_next  = IDLE;
    i_elig      = i_req && (state != GNT_I) && !i_ack;
    d_elig      = d_req && (state != GNT_D) && !d_ack;
    fetch_first = (starve_cnt == LIMIT);
    if (i_elig && (!d_elig || fetch_first)) begin
      state_next = GNT_I;
    end else if (d_elig) begin
      state_next = GNT_D;
    end
  end

  // Starvation counter: counts data grants that overtook a waiting fetch.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!i_req || (state_next == GNT_I)) begin
      starve_cnt_next = '0;
    end else if ((state_next == GNT_D) && (starve_cnt != LIMIT)) begin
      starve_cnt_next = starve_cnt + CNT_W'(1);
    end
  end

  // Grant state and starvation count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Capture the winning request's parameters alongside the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_addr  <= '0;
      gnt_func3 <= F3_W;
      gnt_wdata <= '0;
      gnt_we    <= 1'b0;
      gnt_err   <= 1'b0;
    end else if (state_next == GNT_I) begin
      gnt_addr  <= i_addr;
      gnt_func3 <= F3_W;
      gnt_wdata <= '0;
      gnt_we    <= 1'b0;
      gnt_err   <= 1'b0;
    end else if (state_next == GNT_D) begin
      gnt_addr  <= d_addr;
      gnt_func3 <= d_func3;
      gnt_wdata <= d_wdata;
      gnt_we    <= d_we;
      gnt_err   <= d_chk_err;
    end
  end

  // Memory strobes and address decoded from the registered grant; a faulting
  // data access consumes its slot but never touches the array.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_func3 = F3_W;
    mem_wdata = '0;
    case (state)
      GNT_I: begin
        mem_addr = gnt_addr;
      end
      GNT_D: begin
        mem_addr  = gnt_addr;
        mem_func3 = gnt_func3;
        if (!gnt_err) begin
          if (gnt_we) begin
            mem_write = 1'b1;
            mem_wdata = gnt_wdata;
          end else begin
            mem_read = 1'b1;
          end
        end
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

  // Acks and read data are registered at the end of the access cycle; read
  // data holds until the next ack of the same port.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_ack   <= 1'b0;
      i_rdata <= '0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      d_rdata <= '0;
    end else begin
      i_ack <= (state == GNT_I);
      d_ack <= (state == GNT_D);
      d_err <= (state == GNT_D) && gnt_err;
      if (state == GNT_I) begin
        i_rdata <= mem_rdata;
      end
      if (state == GNT_D) begin
        d_rdata <= (gnt_we || gnt_err) ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a byte-array memory stub, a table
// of single transactions, and hand-written contention/starvation/reset sequences.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [11:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_func3;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_read;
  logic        mem_write;
  logic [11:0] mem_addr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_func3(mem_func3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Big-endian byte memory, combinational read with sign/zero extension.
  logic [7:0]  mem [0:4095];
  logic [11:0] a0, a1, a2, a3;

  always_comb begin
    a0 = mem_addr;
    a1 = mem_addr + 12'd1;
    a2 = mem_addr + 12'd2;
    a3 = mem_addr + 12'd3;
    mem_rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
    case (mem_func3)
      F3_B:  mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
      F3_BU: mem_rdata = {24'h0, mem[a0]};
      F3_H:  mem_rdata = {{16{mem[a0][7]}}, mem[a0], mem[a1]};
      F3_HU: mem_rdata = {16'h0, mem[a0], mem[a1]};
      default: mem_rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  // Memory write port, sampled on the rising edge.
  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_func3)
        F3_B: mem[a0] = mem_wdata[7:0];
        F3_H: begin
          mem[a0] = mem_wdata[15:8];
          mem[a1] = mem_wdata[7:0];
        end
        default: begin
          mem[a0] = mem_wdata[31:24];
          mem[a1] = mem_wdata[23:16];
          mem[a2] = mem_wdata[15:8];
          mem[a3] = mem_wdata[7:0];
        end
      endcase
    end
  end

  typedef struct {
    logic        fetch;
    logic        we;
    logic [2:0]  func3;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_read;
    logic        exp_write;
  } vec_t;

  vec_t vecs [19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // One isolated transaction: request in N, access in N+1, ack in N+2, quiet in N+3.
  task automatic applyStimulus(input vec_t v, input int k);
    if (v.fetch) begin
      i_req  = 1'b1;
      i_addr = v.addr;
    end else begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_func3 = v.func3;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end
    step();
    checkOutput($sformatf("v%0d_mem_read", k), 32'(mem_read), 32'(v.exp_read));
    checkOutput($sformatf("v%0d_mem_write", k), 32'(mem_write), 32'(v.exp_write));
    if (!v.exp_err) begin
      checkOutput($sformatf("v%0d_mem_addr", k), 32'(mem_addr), 32'(v.addr));
      checkOutput($sformatf("v%0d_mem_func3", k), 32'(mem_func3), v.fetch ? 32'(F3_W) : 32'(v.func3));
    end
    if (v.exp_write) begin
      checkOutput($sformatf("v%0d_mem_wdata", k), mem_wdata, v.wdata);
    end
    step();
    if (v.fetch) begin
      checkOutput($sformatf("v%0d_i_ack", k), 32'(i_ack), 32'd1);
      checkOutput($sformatf("v%0d_i_rdata", k), i_rdata, v.exp_rdata);
      i_req = 1'b0;
    end else begin
      checkOutput($sformatf("v%0d_d_ack", k), 32'(d_ack), 32'd1);
      checkOutput($sformatf("v%0d_d_err", k), 32'(d_err), 32'(v.exp_err));
      checkOutput($sformatf("v%0d_d_rdata", k), d_rdata, v.exp_rdata);
      d_req = 1'b0;
    end
    step();
    checkOutput($sformatf("v%0d_ack_pulse", k), 32'(v.fetch ? i_ack : d_ack), 32'd0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] cnt_at_grant;
    int          ack_cycle;
    bit          got_ack;

    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    mem[12'h000] = 8'h00; mem[12'h001] = 8'h01; mem[12'h002] = 8'h90; mem[12'h003] = 8'h83;
    mem[12'h004] = 8'h13; mem[12'h005] = 8'h57; mem[12'h006] = 8'h9B; mem[12'h007] = 8'hDF;
    mem[12'h193] = 8'h11;
    mem[12'hFFE] = 8'hAA; mem[12'hFFF] = 8'hBB;

    //           fetch we  func3  addr     wdata          exp_rdata      err   rd    wr
    vecs[0]  = '{1'b1, 1'b0, F3_W,  12'h000, 32'h0,         32'h00019083, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, F3_W,  12'h190, 32'h0,         32'h00000011, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, F3_W,  12'h1A0, 32'hDEADBEEF,  32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, F3_W,  12'h1A0, 32'h0,         32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, F3_H,  12'h1A2, 32'h0,         32'hFFFFBEEF, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, F3_HU, 12'h1A2, 32'h0,         32'h0000BEEF, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, F3_B,  12'h1A0, 32'h0,         32'hFFFFFFDE, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, F3_BU, 12'h1A1, 32'h0,         32'h000000AD, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, F3_B,  12'h1A3, 32'h12345677,  32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, F3_W,  12'h1A0, 32'h0,         32'hDEADBE77, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, F3_W,  12'h19E, 32'hCAFEF00D,  32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, F3_H,  12'h191, 32'h0,         32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, F3_BU, 12'h1B0, 32'h000000FF,  32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 3'b011,12'h1A0, 32'h0,         32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, F3_W,  12'h19C, 32'h0,         32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, F3_W,  12'h1A0, 32'h0,         32'hDEADBE77, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, F3_BU, 12'h1B0, 32'h0,         32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, F3_W,  12'h002, 32'h0,         32'h90831357, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, F3_W,  12'hFFE, 32'h0,         32'hAABB0001, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_func3 = 3'b000; d_addr = '0; d_wdata = '0;
    step();
    step();
    rst = 1'b0;
    step();
    $display("[TB] reset state");
    checkOutput("rst_i_ack", 32'(i_ack), 32'd0);
    checkOutput("rst_d_ack", 32'(d_ack), 32'd0);
    checkOutput("rst_d_err", 32'(d_err), 32'd0);
    checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_func3", 32'(mem_func3), 32'(3'b010));
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_i_rdata", i_rdata, 32'd0);
    checkOutput("rst_d_rdata", d_rdata, 32'd0);

    $display("[TB] vector table");
    for (int k = 0; k < 19; k++) begin
      applyStimulus(vecs[k], k);
    end

    // Contention: data wins first, fetch follows back-to-back.
    $display("[TB] contention");
    i_req = 1'b1; i_addr = 12'h004;
    d_req = 1'b1; d_we = 1'b0; d_func3 = F3_W; d_addr = 12'h190;
    step();
    checkOutput("cont_n1_mem_read", 32'(mem_read), 32'd1);
    checkOutput("cont_n1_mem_addr", 32'(mem_addr), 32'h190);
    step();
    checkOutput("cont_n2_d_ack", 32'(d_ack), 32'd1);
    checkOutput("cont_n2_d_rdata", d_rdata, 32'h00000011);
    checkOutput("cont_n2_i_ack", 32'(i_ack), 32'd0);
    checkOutput("cont_n2_mem_addr", 32'(mem_addr), 32'h004);
    checkOutput("cont_n2_mem_read", 32'(mem_read), 32'd0);
    d_req = 1'b0;
    step();
    checkOutput("cont_n3_i_ack", 32'(i_ack), 32'd1);
    checkOutput("cont_n3_i_rdata", i_rdata, 32'h13579BDF);
    checkOutput("cont_n3_d_ack", 32'(d_ack), 32'd0);
    i_req = 1'b0;
    step();

    // Starvation guard: fetch held, data kept requesting every cycle.
    $display("[TB] starvation");
    cnt_at_grant = 32'hFFFF_FFFF;
    got_ack = 1'b0;
    ack_cycle = 0;
    i_req = 1'b1; i_addr = 12'h000;
    d_req = 1'b1; d_we = 1'b0; d_func3 = F3_W; d_addr = 12'h190;
    for (int c = 1; c <= 12 && !got_ack; c++) begin
      step();
      if (dut.state == GNT_I && cnt_at_grant == 32'hFFFF_FFFF) cnt_at_grant = 32'(dut.starve_cnt);
      if (i_ack) begin
        got_ack = 1'b1;
        ack_cycle = c;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    checkOutput("starve_fetch_acked", 32'(got_ack), 32'd1);
    checkOutput("starve_ack_in_time", 32'(got_ack && ack_cycle <= 10), 32'd1);
    checkOutput("starve_cnt_cleared", cnt_at_grant, 32'd0);
    checkOutput("starve_i_rdata", i_rdata, 32'h00019083);
    step();
    step();
    step();

    // Reset during a store's access cycle drops it without an ack.
    $display("[TB] reset mid-op");
    d_req = 1'b1; d_we = 1'b1; d_func3 = F3_W; d_addr = 12'h1C0; d_wdata = 32'h11223344;
    step();
    checkOutput("rmid_mem_write_before", 32'(mem_write), 32'd1);
    rst = 1'b1;
    step();
    checkOutput("rmid_state", 32'(dut.state), 32'(IDLE));
    checkOutput("rmid_mem_write_after", 32'(mem_write), 32'd0);
    checkOutput("rmid_d_ack", 32'(d_ack), 32'd0);
    rst = 1'b0;
    d_req = 1'b0;
    step();
    checkOutput("rmid_d_ack_later", 32'(d_ack), 32'd0);
    checkOutput("rmid_mem_write_later", 32'(mem_write), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
